console_uart_tx: RTL and testbench
==================================

# console_uart_tx

Memory-mapped console transmitter sitting on the core's data-memory write port beside data memory. Byte stores to the console address are queued in a small FIFO and serialized on a UART TX line (8N1, LSB first). A status word is exposed for polling. This makes the simulation-only console print path a real hardware output.

## Interface
- `ADDR`, default 32'h0000_FFFC: data address of the console register (65532).
- `STATUS_ADDR`, default 32'h0000_FFF8: data address of the status register.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, default 8: FIFO entries; power of 2, ≥2.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `memwrite` in 1: store strobe from the core, one cycle per store.
- `dataadr` in 32: store address.
- `writedata` in 32: store data; only [7:0] is transmitted.
- `tx` out 1: UART line; idles high.
- `busy` out 1: transmit FSM not in IDLE.
- `overflow` out 1: sticky flag, set when a byte is dropped.
- `status_rdata` out 32: combinational status word.
  - bit0 = busy
  - bit1 = full
  - bit2 = empty
  - bit3 = overflow
  - [15:8] = FIFO count, zero-extended
  - all other bits 0

## Operation
- **Push.** Occurs when `memwrite && dataadr==ADDR`.
  - If not full: `writedata[7:0]` is written at the tail.
  - If full: the byte is dropped and `overflow` is set.
- **Status clear.** `memwrite && dataadr==STATUS_ADDR` clears `overflow`; the data value is ignored.
- **Other addresses.** Stores to any other address have no effect.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the registered count ≠0. The head is popped into the shift register and the baud counter is loaded with `CLKS_PER_BIT`-1.
  - START: `tx`=0. When the counter reaches 0, go to DATA with bit index 0.
  - DATA: `tx`=`shift[0]`. At each counter expiry, shift right and increment the index. After index 7 expires, go to STOP.
  - STOP: `tx`=1. At counter expiry:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Registered output.** `tx` is driven from a flop; no combinational path from inputs to `tx`.
- **Width rules.**
  - Baud counter width is `$clog2(CLKS_PER_BIT)`.
  - FIFO count width is `$clog2(FIFO_DEPTH)`+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Simultaneous push and pop.**
  - When full: both occur, the push is accepted, and the count is unchanged.
  - When empty: no pop occurs (the FSM sees the registered count), so there is no fall-through.
- **Simultaneous push-overflow and status clear:** the clear wins, so `overflow` ends at 0.

## Timing
- **Reset values:**
  - `tx`=1, `busy`=0, `overflow`=0;
  - count=0, so `status_rdata`=32'h0000_0004;
  - FSM in IDLE, FIFO pointers 0.
- **Reset mid-frame:** the frame is abandoned, `tx`=1 on the cycle after the reset edge, and queued bytes are discarded.
- **Start-bit latency.** A push sampled at edge E0 makes count=1 after E0. At E1 the FSM pops, so `tx`=0 and `busy`=1 after E1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles (start, 8 data, stop).
- **Back-to-back frames:** the next start bit immediately follows the last stop-bit cycle.
- **Return to idle:** `busy` falls on the edge that ends STOP when the FIFO is empty.
- **Status timing:** `status_rdata` reflects state registered at the most recent edge.

## Structure
- **Package `console_pkg`** holds:
  - `CONSOLE_ADDR` and `CONSOLE_STATUS_ADDR` constants;
  - `tx_state_t` enum {IDLE, START, DATA, STOP};
  - status bit-index localparams.
- **Sub-module `sync_fifo`** (parameter `WIDTH`, `DEPTH`; ports push, pop, wdata, rdata, full, empty, count).
  - `rdata` is the head entry, valid whenever not empty.
  - Reset is synchronous and empties the FIFO.
- **Top level** holds the address decode, the FSM, baud counter, shift register and the `overflow` flop.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.

1. **Single byte.** Store 32'h1234_5641 to 0xFFFC → `tx` low 1 cycle after the push edge. Bits 1,0,0,0,0,0,1,0 follow at 4 cycles each, then stop high. `busy` lasts 40 cycles.
2. **Back-to-back.** Three consecutive stores (0x55, 0xAA, 0x0F) → 120 contiguous `tx` cycles with no idle gap. Count in `status_rdata`[15:8] reads 2 after the first pop.
3. **Overflow.** 10 stores in 10 cycles → 1 popped, 8 queued, 1 dropped. `overflow`=1 and `status_rdata`[3]=1. Exactly 9 frames are transmitted. A store to 0xFFF8 clears `overflow`.
4. **Address filter.** Stores to 0xFFF4 and 0x0000_FFFD → no push, `tx` stays 1, `status_rdata`=0x4.
5. **Reset mid-frame.** Assert reset during DATA bit 3 with 2 bytes queued → `tx`=1, `busy`=0 and `status_rdata`=0x4 on the next cycle. No frames follow.
6. **Push while full, with pop.** Fill the FIFO while busy. Push on the exact STOP-expiry cycle that pops → push accepted, count stays 8, `overflow` stays 0.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants and types for the memory-mapped console transmitter.
package console_pkg;

    // Default data addresses of the console byte port and its status word
    localparam logic [31:0] CONSOLE_ADDR        = 32'h0000_FFFC;
    localparam logic [31:0] CONSOLE_STATUS_ADDR = 32'h0000_FFF8;

    // Serial frame shape: 8 data bits, no parity, one stop bit
    localparam int NUM_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Status word layout
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_EMPTY_BIT    = 2;
    localparam int STAT_OVERFLOW_BIT = 3;
    localparam int STAT_COUNT_LSB    = 8;
    localparam int STAT_COUNT_MSB    = 15;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// The head entry is presented on rdata whenever the FIFO is not empty.
// A push is accepted while full only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Qualify requests and work out the next occupancy
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// Console transmitter on the core's data-memory write port.
// Byte stores to ADDR are queued and sent as 8N1 frames, LSB first.
// Stores to STATUS_ADDR clear the sticky overflow flag.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | driving the start bit (low)
// DATA  | driving data bit bit_idx_q from shift_q[0]
// STOP  | driving the stop bit (high); pops the next byte on expiry
module console_uart_tx
    import console_pkg::*;
#(
    parameter logic [31:0] ADDR         = CONSOLE_ADDR,
    parameter logic [31:0] STATUS_ADDR  = CONSOLE_STATUS_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] status_rdata
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(NUM_DATA_BITS - 1);

    tx_state_t         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_idx_q;
    logic              tx_q;
    logic              busy_q;
    logic              overflow_q;
    logic              overflow_d;

    logic              push_req;
    logic              clr_req;
    logic              baud_done;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;

    // Only the low byte of a store is transmitted
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:8];

    // Address decode and pop decision; the FSM only looks at registered occupancy
    always_comb begin
        push_req  = memwrite && (dataadr == ADDR);
        clr_req   = memwrite && (dataadr == STATUS_ADDR);
        baud_done = (baud_q == '0);
        fifo_pop  = ((state_q == IDLE) || ((state_q == STOP) && baud_done)) && !fifo_empty;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (writedata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transmit FSM with baud down-counter, shift register and registered line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        state_q <= START;
                        shift_q <= fifo_rdata;
                        baud_q  <= BAUD_LOAD;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        baud_q    <= BAUD_LOAD;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= BAUD_LOAD;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                STOP: begin
                    if (fifo_pop) begin
                        // Next frame starts right after the stop bit, no idle gap
                        state_q <= START;
                        shift_q <= fifo_rdata;
                        baud_q  <= BAUD_LOAD;
                        tx_q    <= 1'b0;
                    end else if (baud_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: set on a dropped byte, a status store clears it and wins
    always_comb begin
        overflow_d = overflow_q;
        if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;
        if (clr_req) overflow_d = 1'b0;
    end

    // Overflow flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Status word built from registered state
    always_comb begin
        status_rdata                                  = '0;
        status_rdata[STAT_BUSY_BIT]                   = busy_q;
        status_rdata[STAT_FULL_BIT]                   = fifo_full;
        status_rdata[STAT_EMPTY_BIT]                  = fifo_empty;
        status_rdata[STAT_OVERFLOW_BIT]               = overflow_q;
        status_rdata[STAT_COUNT_MSB:STAT_COUNT_LSB]   = 8'(fifo_count);
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_console_uart_tx;

    localparam logic [31:0] A_TX   = 32'h0000_FFFC;
    localparam logic [31:0] A_STAT = 32'h0000_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [31:0] status_rdata;

    int n_pass  = 0;
    int n_total = 0;

    console_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .status_rdata (status_rdata)
    );

    always #5 clk = ~clk;

    // Expected line level at cycle c (0..39) of a frame carrying byte b
    function automatic logic exp_tx(input logic [7:0] b, input int c);
        if (c < 4) return 1'b0;
        else if (c < 36) return b[(c - 4) / 4];
        else return 1'b1;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        @(posedge clk); #1;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        memwrite = 1'b0; dataadr = '0; writedata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_total++;
        if ({tx, busy, overflow} !== 3'b100) $display("FAIL reset_outputs tx/busy/ovf got %b want 100", {tx, busy, overflow});
        else n_pass++;
        n_total++;
        if (status_rdata !== 32'h0000_0004) $display("FAIL reset_status got %h want 00000004", status_rdata);
        else n_pass++;
    endtask

    task automatic test_single_byte;
        do_store(A_TX, 32'h1234_5641);
        n_total++;
        if (tx !== 1'b1 || status_rdata !== 32'h0000_0100) $display("FAIL single_after_push tx=%b status=%h want tx=1 status=00000100", tx, status_rdata);
        else n_pass++;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            n_total++;
            if (tx !== exp_tx(8'h41, c) || busy !== 1'b1) $display("FAIL single_frame cyc %0d tx=%b busy=%b want tx=%b busy=1", c, tx, busy, exp_tx(8'h41, c));
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0 || tx !== 1'b1 || status_rdata !== 32'h0000_0004) $display("FAIL single_idle busy=%b tx=%b status=%h want 0 1 00000004", busy, tx, status_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3] = '{8'h55, 8'hAA, 8'h0F};
        memwrite = 1'b1; dataadr = A_TX; writedata = {24'h0, bytes[0]};
        for (int cyc = 0; cyc <= 120; cyc++) begin
            @(posedge clk); #1;
            if (cyc + 1 < 3) writedata = {24'h0, bytes[cyc + 1]};
            else begin memwrite = 1'b0; dataadr = '0; writedata = '0; end
            if (cyc >= 1) begin
                n_total++;
                if (tx !== exp_tx(bytes[(cyc - 1) / 40], (cyc - 1) % 40) || busy !== 1'b1)
                    $display("FAIL b2b_frame cyc %0d tx=%b busy=%b want tx=%b busy=1", cyc, tx, busy, exp_tx(bytes[(cyc - 1) / 40], (cyc - 1) % 40));
                else n_pass++;
            end
            if (cyc == 2) begin
                n_total++;
                if (status_rdata !== 32'h0000_0201) $display("FAIL b2b_status got %h want 00000201", status_rdata);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL b2b_idle busy=%b tx=%b want 0 1", busy, tx);
        else n_pass++;
    endtask

    task automatic test_overflow;
        memwrite = 1'b1; dataadr = A_TX; writedata = 32'h30;
        for (int cyc = 0; cyc <= 360; cyc++) begin
            @(posedge clk); #1;
            if (cyc + 1 < 10) writedata = 32'h30 + 32'(cyc + 1);
            else begin memwrite = 1'b0; dataadr = '0; writedata = '0; end
            if (cyc >= 1) begin
                n_total++;
                if (tx !== exp_tx(8'h30 + 8'((cyc - 1) / 40), (cyc - 1) % 40) || busy !== 1'b1)
                    $display("FAIL ovf_frame cyc %0d tx=%b busy=%b want tx=%b busy=1", cyc, tx, busy, exp_tx(8'h30 + 8'((cyc - 1) / 40), (cyc - 1) % 40));
                else n_pass++;
            end
            if (cyc == 9) begin
                n_total++;
                if (status_rdata !== 32'h0000_080B || overflow !== 1'b1) $display("FAIL ovf_status got %h ovf=%b want 0000080B ovf=1", status_rdata, overflow);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0 || overflow !== 1'b1 || status_rdata !== 32'h0000_000C) $display("FAIL ovf_after_drain busy=%b ovf=%b status=%h want 0 1 0000000C", busy, overflow, status_rdata);
        else n_pass++;
        do_store(A_STAT, 32'hFFFF_FFFF);
        n_total++;
        if (overflow !== 1'b0 || status_rdata !== 32'h0000_0004) $display("FAIL ovf_clear ovf=%b status=%h want 0 00000004", overflow, status_rdata);
        else n_pass++;
    endtask

    task automatic test_addr_filter;
        do_store(32'h0000_FFF4, 32'h41);
        do_store(32'h0000_FFFD, 32'h41);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_total++;
            if (tx !== 1'b1 || busy !== 1'b0 || status_rdata !== 32'h0000_0004) $display("FAIL addr_filter cyc %0d tx=%b busy=%b status=%h want 1 0 00000004", c, tx, busy, status_rdata);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame;
        do_store(A_TX, 32'h41);
        do_store(A_TX, 32'h42);
        do_store(A_TX, 32'h43);
        n_total++;
        if (status_rdata[15:8] !== 8'd2) $display("FAIL rmf_count got %0d want 2", status_rdata[15:8]);
        else n_pass++;
        repeat (16) @(posedge clk);
        #1;
        n_total++;
        if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL rmf_bit3 tx=%b busy=%b want 0 1", tx, busy);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if (tx !== 1'b1 || busy !== 1'b0 || status_rdata !== 32'h0000_0004) $display("FAIL rmf_after_reset tx=%b busy=%b status=%h want 1 0 00000004", tx, busy, status_rdata);
        else n_pass++;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            n_total++;
            if ({tx, busy} !== 2'b10) $display("FAIL rmf_quiet cyc %0d tx/busy got %b want 10", c, {tx, busy});
            else n_pass++;
        end
    endtask

    task automatic test_push_full_pop;
        for (int i = 0; i < 9; i++) do_store(A_TX, 32'h60 + 32'(i));
        repeat (32) @(posedge clk);
        #1;
        n_total++;
        if (status_rdata !== 32'h0000_0803) $display("FAIL pfp_before got %h want 00000803", status_rdata);
        else n_pass++;
        do_store(A_TX, 32'h7E);
        n_total++;
        if (status_rdata !== 32'h0000_0803 || overflow !== 1'b0) $display("FAIL pfp_after got %h ovf=%b want 00000803 ovf=0", status_rdata, overflow);
        else n_pass++;
        n_total++;
        if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL pfp_next_start tx=%b busy=%b want 0 1", tx, busy);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if (status_rdata !== 32'h0000_0004) $display("FAIL pfp_cleanup got %h want 00000004", status_rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_addr_filter();
        test_reset_mid_frame();
        test_push_full_pop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
